// File: rtl/calendar_counter_if.sv
// Time-set load and calendar output bundle between calendar_counter and its host/formatter.
interface calendar_counter_if;
  logic        set_en;
  logic [11:0] set_year;
  logic [7:0]  set_month;
  logic [7:0]  set_day;
  logic [7:0]  set_hour;
  logic [7:0]  set_minute;
  logic [7:0]  set_second;
  logic [2:0]  set_week;
  logic [11:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic [2:0]  week;
  logic        leap_year;
  logic        day_tick;
  logic        load_err;

  modport master (
    output set_en, set_year, set_month, set_day, set_hour, set_minute, set_second, set_week,
    input  year, month, day, hour, minute, second, week, leap_year, day_tick, load_err
  );

  modport slave (
    input  set_en, set_year, set_month, set_day, set_hour, set_minute, set_second, set_week,
    output year, month, day, hour, minute, second, week, leap_year, day_tick, load_err
  );
endinterface

// File: rtl/calendar_counter.sv
// Gregorian calendar/clock advanced once per clk1sec edge, with validated parallel load.
// Define CAL_HOLD_EN to add a hold input that freezes counting (loads still honoured).
module calendar_counter #(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099,
  parameter int RST_WEEK = 6
) (
  input  logic clk1sec,
  input  logic rst,
`ifdef CAL_HOLD_EN
  input  logic hold,
`endif
  calendar_counter_if.slave bus
);

  localparam logic [11:0] Y_MIN = 12'(YEAR_MIN);
  localparam logic [11:0] Y_MAX = 12'(YEAR_MAX);
  localparam logic [2:0]  W_RST = 3'(RST_WEEK);

  // set_en is a valid-only strobe with no ready: every request is consumed on its
  // edge, either as a full load or, if any field is illegal, as a load_err pulse.

  logic [11:0] year_q, n_year;
  logic [7:0]  month_q, n_month, day_q, n_day, hour_q, n_hour;
  logic [7:0]  minute_q, n_minute, second_q, n_second;
  logic [2:0]  week_q, n_week;
  logic        day_tick_q, n_day_tick, load_err_q, n_load_err;
  logic        set_legal, hold_act;

  function automatic logic is_leap(input logic [11:0] y);
    return (((y % 12'd4) == 12'd0) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
  endfunction

  function automatic logic [7:0] month_len(input logic [11:0] y, input logic [7:0] m);
    logic [7:0] len;
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: len = 8'd30;
      8'd2:                    len = is_leap(y) ? 8'd29 : 8'd28;
      default:                 len = 8'd31;
    endcase
    return len;
  endfunction

`ifdef CAL_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  assign set_legal = (bus.set_year >= Y_MIN) && (bus.set_year <= Y_MAX) &&
                     (bus.set_month >= 8'd1) && (bus.set_month <= 8'd12) &&
                     (bus.set_day >= 8'd1) &&
                     (bus.set_day <= month_len(bus.set_year, bus.set_month)) &&
                     (bus.set_hour < 8'd24) && (bus.set_minute < 8'd60) &&
                     (bus.set_second < 8'd60) && (bus.set_week < 3'd7);

  always_comb begin
    n_year     = year_q;
    n_month    = month_q;
    n_day      = day_q;
    n_hour     = hour_q;
    n_minute   = minute_q;
    n_second   = second_q;
    n_week     = week_q;
    n_day_tick = 1'b0;
    n_load_err = 1'b0;
    if (bus.set_en && set_legal) begin
      n_year   = bus.set_year;
      n_month  = bus.set_month;
      n_day    = bus.set_day;
      n_hour   = bus.set_hour;
      n_minute = bus.set_minute;
      n_second = bus.set_second;
      n_week   = bus.set_week;
    end else begin
      n_load_err = bus.set_en;
      if (!hold_act) begin
        if (second_q != 8'd59) begin
          n_second = second_q + 8'd1;
        end else begin
          n_second = 8'd0;
          if (minute_q != 8'd59) begin
            n_minute = minute_q + 8'd1;
          end else begin
            n_minute = 8'd0;
            if (hour_q != 8'd23) begin
              n_hour = hour_q + 8'd1;
            end else begin
              n_hour     = 8'd0;
              n_day_tick = 1'b1;
              n_week     = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
              if (day_q != month_len(year_q, month_q)) begin
                n_day = day_q + 8'd1;
              end else begin
                n_day = 8'd1;
                if (month_q != 8'd12) begin
                  n_month = month_q + 8'd1;
                end else begin
                  n_month = 8'd1;
                  // The range wrap restarts the weekday too, so YEAR_MIN-01-01 is always RST_WEEK.
                  if (year_q == Y_MAX) begin
                    n_year = Y_MIN;
                    n_week = W_RST;
                  end else begin
                    n_year = year_q + 12'd1;
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      year_q     <= Y_MIN;
      month_q    <= 8'd1;
      day_q      <= 8'd1;
      hour_q     <= 8'd0;
      minute_q   <= 8'd0;
      second_q   <= 8'd0;
      week_q     <= W_RST;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      year_q     <= n_year;
      month_q    <= n_month;
      day_q      <= n_day;
      hour_q     <= n_hour;
      minute_q   <= n_minute;
      second_q   <= n_second;
      week_q     <= n_week;
      day_tick_q <= n_day_tick;
      load_err_q <= n_load_err;
    end
  end

  assign bus.year      = year_q;
  assign bus.month     = month_q;
  assign bus.day       = day_q;
  assign bus.hour      = hour_q;
  assign bus.minute    = minute_q;
  assign bus.second    = second_q;
  assign bus.week      = week_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.load_err  = load_err_q;
  assign bus.leap_year = is_leap(year_q);

endmodule
